// File: rtl/fifo_stream_reader_if.sv
// ------------------------------------------------------------------
// Module : fifo_stream_reader_if
// Brief  : Output beat stream (valid/ready with last marker).
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fifo_stream_reader_if #(
  parameter int DW = 32
);
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ------------------------------------------------------------------
// Module : fifo_stream_reader
// Brief  : Drains a FIFO into a packetised stream via a 2-entry skid
//          buffer, with a flush sequence that clears the FIFO.
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
  parameter int DW      = 32,
  parameter int DL      = 2,
  parameter int PKT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_nempty,
  input  logic [DW-1:0]        fifo_rdata,
  input  logic [DL:0]          fifo_occ,
  output logic                 fifo_read,
  output logic                 fifo_clr,
  input  logic                 flush,
  output logic                 flush_done,
  fifo_stream_reader_if.master m_if,
  output logic [15:0]          pkt_cnt,
  output logic [DL+1:0]        level
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_CLR  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  state_t        state_q, state_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  logic          m_valid;
  logic          m_last;
  logic          hs;
  logic          new_last;
  logic [1:0]    wr_slot;

  always_comb begin
    state_d    = state_q;
    buf_cnt_d  = buf_cnt_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    last0_d    = last0_q;
    last1_d    = last1_q;
    idx_d      = idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    new_last   = 1'b0;

    fifo_read  = (state_q == ST_RUN) && !flush && fifo_nempty && (buf_cnt_q < 2'd2);
    fifo_clr   = (state_q == ST_CLR);
    flush_done = (state_q == ST_DONE);
    m_valid    = (buf_cnt_q != 2'd0);
    m_last     = m_valid && last0_q;
    hs         = m_valid && m_if.m_ready;
    // A pop frees the head before the capture lands, so the tail slot shifts down.
    wr_slot    = buf_cnt_q - {1'b0, hs};

    case (state_q)
      ST_RUN:  if (flush) state_d = ST_CLR;
      ST_CLR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (hs) begin
      data0_d = data1_q;
      last0_d = last1_q;
      if (m_last) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end

    if (fifo_read) begin
      new_last = (idx_q == LAST_IDX);
      idx_d    = new_last ? 8'd0 : idx_q + 8'd1;
      if (wr_slot == 2'd0) begin
        data0_d = fifo_rdata;
        last0_d = new_last;
      end else begin
        data1_d = fifo_rdata;
        last1_d = new_last;
      end
    end

    buf_cnt_d = buf_cnt_q + {1'b0, fifo_read} - {1'b0, hs};

    if ((state_q == ST_RUN) && flush) begin
      buf_cnt_d = 2'd0;
      idx_d     = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      buf_cnt_q <= 2'd0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      idx_q     <= 8'd0;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      buf_cnt_q <= buf_cnt_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m_if.m_valid = m_valid;
  assign m_if.m_data  = data0_q;
  assign m_if.m_last  = m_last;
  assign pkt_cnt      = pkt_cnt_q;
  assign level        = (DL+2)'(fifo_occ) + (DL+2)'(buf_cnt_q);

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ------------------------------------------------------------------
// Module : tb_fifo_stream_reader
// Brief  : Scoreboard bench: FIFO model drives the reader, a monitor
//          checks every accepted beat against queued expectations.
// Rev    : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fifo_stream_reader;

  localparam int DW      = 32;
  localparam int DL      = 3;
  localparam int PKT_LEN = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_nempty;
  logic [DW-1:0] fifo_rdata;
  logic [DL:0]   fifo_occ;
  logic          fifo_read;
  logic          fifo_clr;
  logic          flush;
  logic          flush_done;
  logic [15:0]   pkt_cnt;
  logic [DL+1:0] level;

  fifo_stream_reader_if #(.DW(DW)) m_if ();

  fifo_stream_reader #(.DW(DW), .DL(DL), .PKT_LEN(PKT_LEN)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fifo_nempty (fifo_nempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_occ    (fifo_occ),
    .fifo_read   (fifo_read),
    .fifo_clr    (fifo_clr),
    .flush       (flush),
    .flush_done  (flush_done),
    .m_if        (m_if),
    .pkt_cnt     (pkt_cnt),
    .level       (level)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [DW-1:0]  fq[$];
  logic [DW-1:0]  sb_data[$];
  logic           sb_last[$];
  int             exp_idx = 0;
  logic [DW-1:0]  mon_d;
  logic           mon_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task fifo_refresh();
    fifo_nempty <= (fq.size() != 0);
    fifo_rdata  <= (fq.size() != 0) ? fq[0] : '0;
    fifo_occ    <= 4'(fq.size());
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    sb_data.push_back(w);
    sb_last.push_back(exp_idx == PKT_LEN - 1);
    exp_idx = (exp_idx == PKT_LEN - 1) ? 0 : exp_idx + 1;
    fifo_refresh();
  endtask

  task automatic discard_expected();
    sb_data.delete();
    sb_last.delete();
    exp_idx = 0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb_data.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #2;
    check(name, 64'(sb_data.size()), 64'd0);
  endtask

  // FIFO model: pop/clear on the same edge the DUT captures.
  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    else if (fifo_read && fq.size() != 0) void'(fq.pop_front());
    fifo_refresh();
  end

  always @(negedge clk) begin
    if (rstn && m_if.m_valid && m_if.m_ready) begin
      if (sb_data.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_unexpected: got data %0h, required no beat", m_if.m_data);
      end else begin
        mon_d = sb_data.pop_front();
        mon_l = sb_last.pop_front();
        check("beat_data", 64'(m_if.m_data), 64'(mon_d));
        check("beat_last", 64'(m_if.m_last), 64'(mon_l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, last_rd, cnt_rd, first_v, last_v, cnt_v;
    int pulses, bad_rd, bad_v, bad_lvl;
    logic [DW-1:0] held;
    logic held_bad;

    rstn        = 1'b0;
    flush       = 1'b0;
    m_if.m_ready = 1'b0;
    fifo_refresh();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid",    64'(m_if.m_valid), 64'd0);
    check("rst_m_last",     64'(m_if.m_last),  64'd0);
    check("rst_fifo_read",  64'(fifo_read),    64'd0);
    check("rst_fifo_clr",   64'(fifo_clr),     64'd0);
    check("rst_flush_done", 64'(flush_done),   64'd0);
    check("rst_pkt_cnt",    64'(pkt_cnt),      64'd0);
    check("rst_level",      64'(level),        64'd0);
    rstn = 1'b1;

    // Steady stream of 8 words.
    @(posedge clk); #1;
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
    first_rd = -1; last_rd = -1; cnt_rd = 0;
    first_v  = -1; last_v  = -1; cnt_v  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_read) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        cnt_rd++;
      end
      if (m_if.m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        cnt_v++;
      end
    end
    check("stream_read_count",  64'(cnt_rd),            64'd8);
    check("stream_read_span",   64'(last_rd - first_rd), 64'd7);
    check("stream_valid_count", 64'(cnt_v),             64'd8);
    check("stream_valid_span",  64'(last_v - first_v),   64'd7);
    check("stream_latency",     64'(first_v - first_rd), 64'd1);
    drain("stream_drain");
    check("stream_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Backpressure with 3 words queued.
    @(posedge clk); #1;
    m_if.m_ready = 1'b0;
    push_word(32'h20); push_word(32'h21); push_word(32'h22);
    cnt_rd = 0; held_bad = 1'b0; held = 32'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_read) cnt_rd++;
      if (m_if.m_valid && m_if.m_data !== held) held_bad = 1'b1;
    end
    check("bp_pop_count", 64'(cnt_rd),    64'd2);
    check("bp_data_held", 64'(held_bad),  64'd0);
    check("bp_read_low",  64'(fifo_read), 64'd0);
    check("bp_level",     64'(level),     64'd3);
    @(posedge clk); #1;
    m_if.m_ready = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m_if.m_valid) cnt_v++;
    end
    check("bp_release_no_gap", 64'(cnt_v), 64'd3);
    @(posedge clk); #1;
    push_word(32'h23);
    drain("bp_drain");
    check("bp_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // Flush mid-packet: 2 beats accepted, 3 pending.
    @(posedge clk); #1;
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h30 + 32'(i));
    repeat (4) @(posedge clk);
    #1;
    m_if.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_if.m_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_read", 64'(fifo_read), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    discard_expected();
    @(negedge clk);
    check("clr_fifo_clr",  64'(fifo_clr),     64'd1);
    check("clr_m_valid",   64'(m_if.m_valid), 64'd0);
    check("clr_fifo_read", 64'(fifo_read),    64'd0);
    @(negedge clk);
    check("done_pulse",    64'(flush_done), 64'd1);
    check("done_clr_low",  64'(fifo_clr),   64'd0);
    check("done_pkt_cnt",  64'(pkt_cnt),    64'd3);
    @(negedge clk);
    check("done_one_cycle", 64'(flush_done), 64'd0);
    @(posedge clk); #1;
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h40 + 32'(i));
    drain("flush_refill_drain");
    check("flush_refill_pkt_cnt", 64'(pkt_cnt), 64'd4);

    // Flush coincident with last-beat handshake, second flush during CLR.
    @(posedge clk); #1;
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h50 + 32'(i));
    repeat (4) @(posedge clk);
    #1;
    m_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("coinc_head_last", 64'(m_if.m_last), 64'd1);
    @(posedge clk); #1;
    discard_expected();
    pulses = 0;
    @(negedge clk);
    if (flush_done) pulses++;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush_done) pulses++;
    end
    check("coinc_single_done", 64'(pulses),  64'd1);
    check("coinc_pkt_cnt",     64'(pkt_cnt), 64'd5);

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'h60 + 32'(i));
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b0;
    fq.delete();
    fifo_refresh();
    discard_expected();
    #1;
    check("arst_m_valid",    64'(m_if.m_valid), 64'd0);
    check("arst_m_last",     64'(m_if.m_last),  64'd0);
    check("arst_pkt_cnt",    64'(pkt_cnt),      64'd0);
    check("arst_fifo_read",  64'(fifo_read),    64'd0);
    check("arst_fifo_clr",   64'(fifo_clr),     64'd0);
    check("arst_flush_done", 64'(flush_done),   64'd0);
    check("arst_level",      64'(level),        64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h70 + 32'(i));
    drain("arst_drain");
    check("arst_pkt_cnt_after", 64'(pkt_cnt), 64'd1);

    // Empty FIFO for 20 cycles.
    @(posedge clk); #1;
    bad_rd = 0; bad_v = 0; bad_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_read !== 1'b0) bad_rd++;
      if (m_if.m_valid !== 1'b0) bad_v++;
      if (level !== 5'(fifo_occ)) bad_lvl++;
    end
    check("empty_read_cycles",  64'(bad_rd),  64'd0);
    check("empty_valid_cycles", 64'(bad_v),   64'd0);
    check("empty_level_cycles", 64'(bad_lvl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
